// File: rtl/dmem_arbiter.sv
// dmem_arbiter: merges the two CPU data-memory lanes onto one single-ported
// downstream bus. Each lane owns a one-entry buffer; buffered requests are
// issued oldest-first and every response is routed back to its owner lane.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    lane0_valid,
    input  logic [ADDR_WIDTH-1:0]   lane0_addr,
    input  logic [DATA_WIDTH-1:0]   lane0_wdata,
    input  logic [DATA_WIDTH/8-1:0] lane0_wstrb,
    output logic                    lane0_ready,
    output logic [DATA_WIDTH-1:0]   lane0_rdata,
    output logic                    lane0_error,
    input  logic                    lane1_valid,
    input  logic [ADDR_WIDTH-1:0]   lane1_addr,
    input  logic [DATA_WIDTH-1:0]   lane1_wdata,
    input  logic [DATA_WIDTH/8-1:0] lane1_wstrb,
    output logic                    lane1_ready,
    output logic [DATA_WIDTH-1:0]   lane1_rdata,
    output logic                    lane1_error,
    output logic                    mem_valid,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_error,
    output logic                    busy,
    output logic                    overflow
);
    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT} state_e;

    state_e                state_q;
    logic [1:0]            buf_v_q;
    logic [ADDR_WIDTH-1:0] buf_addr_q  [2];
    logic [DATA_WIDTH-1:0] buf_wdata_q [2];
    logic [STRB_WIDTH-1:0] buf_wstrb_q [2];
    logic                  age_q;       // 1: lane 1 holds the older request
    logic                  owner_q;     // lane whose request is on the bus
    logic [15:0]           tmo_cnt_q;
    logic                  mem_valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [STRB_WIDTH-1:0] mem_wstrb_q;
    logic [1:0]            rsp_ready_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q [2];
    logic [1:0]            rsp_error_q;
    logic                  overflow_q;

    // Lane inputs gathered into arrays; clear drops any same-cycle pulse.
    logic [1:0]            in_v;
    logic [ADDR_WIDTH-1:0] in_addr  [2];
    logic [DATA_WIDTH-1:0] in_wdata [2];
    logic [STRB_WIDTH-1:0] in_wstrb [2];

    assign in_v        = {lane1_valid, lane0_valid} & {2{~clear}};
    assign in_addr[0]  = lane0_addr;
    assign in_addr[1]  = lane1_addr;
    assign in_wdata[0] = lane0_wdata;
    assign in_wdata[1] = lane1_wdata;
    assign in_wstrb[0] = lane0_wstrb;
    assign in_wstrb[1] = lane1_wstrb;

    logic                  tmo_hit;
    logic [1:0]            free;
    logic [1:0]            accept;
    logic                  ovf_set;
    logic                  start;
    logic                  sel;
    logic                  age_d;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [DATA_WIDTH-1:0] iss_wdata;
    logic [STRB_WIDTH-1:0] iss_wstrb;

    // Classify this cycle's lane pulses and choose the next request to issue.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        free    = 2'b00;
        tmo_hit = (state_q == S_WAIT) && !mem_ready && (tmo_cnt_q == TMO_LAST);
        if ((state_q == S_WAIT) && (mem_ready || tmo_hit)) free[owner_q] = 1'b1;
        // A lane's buffer being freed this cycle can take a new request at once.
        accept  = in_v & (~buf_v_q | free);
        ovf_set = |(in_v & buf_v_q & ~free);
        start   = (state_q == S_IDLE) && !clear && (|(buf_v_q | accept));
        // Buffered requests are older than incoming ones; same-cycle arrivals go lane 0 first.
        if (&buf_v_q)        sel = age_q;
        else if (buf_v_q[0]) sel = 1'b0;
        else if (buf_v_q[1]) sel = 1'b1;
        else                 sel = ~accept[0];
        if (buf_v_q[sel]) begin
            iss_addr  = buf_addr_q[sel];
            iss_wdata = buf_wdata_q[sel];
            iss_wstrb = buf_wstrb_q[sel];
        end else begin
            iss_addr  = in_addr[sel];
            iss_wdata = in_wdata[sel];
            iss_wstrb = in_wstrb[sel];
        end
        age_d = age_q;
        if (&accept)        age_d = 1'b0;
        else if (accept[0]) age_d = buf_v_q[1] && !free[1];
        else if (accept[1]) age_d = !(buf_v_q[0] && !free[0]);
    end

    // Buffers, issue FSM and registered lane/bus outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            buf_v_q     <= '0;
            age_q       <= 1'b0;
            owner_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rsp_ready_q <= '0;
            rsp_error_q <= '0;
            overflow_q  <= 1'b0;
            // NOTE: the buffer payloads are reset too, so nothing undefined can reach an output.
            for (int i = 0; i < 2; i++) begin
                buf_addr_q[i]  <= '0;
                buf_wdata_q[i] <= '0;
                buf_wstrb_q[i] <= '0;
                rsp_rdata_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so later defaults/overrides read old state.
            mem_valid_q <= 1'b0;
            rsp_ready_q <= '0;
            rsp_error_q <= '0;
            overflow_q  <= overflow_q | ovf_set;
            age_q       <= age_d;
            for (int i = 0; i < 2; i++) begin
                rsp_rdata_q[i] <= '0;
                if (clear) begin
                    buf_v_q[i] <= 1'b0;
                end else if (accept[i]) begin
                    buf_v_q[i]     <= 1'b1;
                    buf_addr_q[i]  <= in_addr[i];
                    buf_wdata_q[i] <= in_wdata[i];
                    buf_wstrb_q[i] <= in_wstrb[i];
                end else if (free[i]) begin
                    buf_v_q[i] <= 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_ISSUE;
                        owner_q     <= sel;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= iss_addr;
                        mem_wdata_q <= iss_wdata;
                        mem_wstrb_q <= iss_wstrb;
                    end
                end
                S_ISSUE: begin
                    // A flush here lets the bus pulse finish but discards its response.
                    state_q <= clear ? S_ABORT : S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        tmo_cnt_q <= '0;
                        state_q   <= S_IDLE;
                        if (!clear) begin
                            rsp_ready_q[owner_q] <= 1'b1;
                            rsp_rdata_q[owner_q] <= mem_rdata;
                            rsp_error_q[owner_q] <= mem_error;
                        end
                    end else if (clear) begin
                        tmo_cnt_q <= '0;
                        state_q   <= S_ABORT;
                    end else if (tmo_hit) begin
                        tmo_cnt_q            <= '0;
                        state_q              <= S_ABORT;
                        rsp_ready_q[owner_q] <= 1'b1;
                        rsp_error_q[owner_q] <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                S_ABORT: begin
                    if (mem_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lane0_ready = rsp_ready_q[0];
    assign lane0_rdata = rsp_rdata_q[0];
    assign lane0_error = rsp_error_q[0];
    assign lane1_ready = rsp_ready_q[1];
    assign lane1_rdata = rsp_rdata_q[1];
    assign lane1_error = rsp_error_q[1];
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign busy        = (|buf_v_q) || (state_q != S_IDLE);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected lane responses are queued as the
// stimulus is driven and popped when the owning lane pulses ready.
module tb_dmem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        lane0_valid, lane1_valid;
    logic [31:0] lane0_addr, lane1_addr, lane0_wdata, lane1_wdata;
    logic [3:0]  lane0_wstrb, lane1_wstrb;
    logic        lane0_ready, lane1_ready, lane0_error, lane1_error;
    logic [31:0] lane0_rdata, lane1_rdata;
    logic        mem_valid, mem_ready, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy, overflow;

    typedef struct packed {
        logic        lane;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .lane0_valid(lane0_valid), .lane0_addr(lane0_addr), .lane0_wdata(lane0_wdata),
        .lane0_wstrb(lane0_wstrb), .lane0_ready(lane0_ready), .lane0_rdata(lane0_rdata),
        .lane0_error(lane0_error),
        .lane1_valid(lane1_valid), .lane1_addr(lane1_addr), .lane1_wdata(lane1_wdata),
        .lane1_wstrb(lane1_wstrb), .lane1_ready(lane1_ready), .lane1_rdata(lane1_rdata),
        .lane1_error(lane1_error),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic lane, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.lane  = lane;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // Pops the oldest expected response and compares both lanes against it.
    task automatic check_rsp(input string tag);
        rsp_t e;
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed empty scoreboard expected a queued response", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".ready"}, 64'({lane1_ready, lane0_ready}), e.lane ? 64'd2 : 64'd1);
            chk({tag, ".rdata0"}, 64'(lane0_rdata), e.lane ? 64'd0 : 64'(e.rdata));
            chk({tag, ".rdata1"}, 64'(lane1_rdata), e.lane ? 64'(e.rdata) : 64'd0);
            chk({tag, ".error"}, 64'({lane1_error, lane0_error}),
                e.err ? (e.lane ? 64'd2 : 64'd1) : 64'd0);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".no_ready"}, 64'({lane1_ready, lane0_ready}), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ready"}, 64'({lane1_ready, lane0_ready}), 64'd0);
        chk({tag, ".rdata"}, {lane1_rdata, lane0_rdata}, 64'd0);
        chk({tag, ".error"}, 64'({lane1_error, lane0_error}), 64'd0);
        chk({tag, ".mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, ".mem_wdata"}, 64'({mem_wstrb, mem_wdata}), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0;
        lane0_valid = 1'b0; lane0_addr = '0; lane0_wdata = '0; lane0_wstrb = '0;
        lane1_valid = 1'b0; lane1_addr = '0; lane1_wdata = '0; lane1_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0; mem_error = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Single load on lane 0.
        lane0_valid = 1'b1; lane0_addr = 32'h100;
        tick();
        lane0_valid = 1'b0;
        chk("t1.mem_valid", 64'(mem_valid), 64'd1);
        chk("t1.mem_addr", 64'(mem_addr), 64'h100);
        tick();
        chk("t1.mem_valid_pulse", 64'(mem_valid), 64'd0);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; push_rsp(1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check_rsp("t1");
        tick();
        check_quiet("t1.after");
        chk("t1.busy", 64'(busy), 64'd0);

        // Same-cycle lane 0 store and lane 1 load.
        lane0_valid = 1'b1; lane0_addr = 32'h200; lane0_wdata = 32'h11; lane0_wstrb = 4'hF;
        lane1_valid = 1'b1; lane1_addr = 32'h204; lane1_wstrb = 4'h0;
        tick();
        lane0_valid = 1'b0; lane1_valid = 1'b0;
        chk("t2.mem_valid0", 64'(mem_valid), 64'd1);
        chk("t2.mem_req0", {mem_addr, mem_wdata}, {32'h200, 32'h11});
        chk("t2.mem_wstrb0", 64'(mem_wstrb), 64'hF);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h0; push_rsp(1'b0, 32'h0, 1'b0);
        tick();
        mem_ready = 1'b0;
        check_rsp("t2.lane0");
        chk("t2.gap", 64'(mem_valid), 64'd0);
        tick();
        chk("t2.mem_valid1", 64'(mem_valid), 64'd1);
        chk("t2.mem_addr1", 64'(mem_addr), 64'h204);
        chk("t2.mem_wstrb1", 64'(mem_wstrb), 64'h0);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0001; push_rsp(1'b1, 32'hCAFE0001, 1'b0);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check_rsp("t2.lane1");
        tick();
        chk("t2.busy", 64'(busy), 64'd0);

        // Age order: lane 1 first, lane 0 waits, lane 1 re-requests in its response cycle.
        lane1_valid = 1'b1; lane1_addr = 32'h300;
        tick();
        lane1_valid = 1'b0;
        chk("t3.mem_addr_a", 64'(mem_addr), 64'h300);
        lane0_valid = 1'b1; lane0_addr = 32'h304;
        tick();
        lane0_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h33330000; push_rsp(1'b1, 32'h33330000, 1'b0);
        tick();
        mem_ready = 1'b0;
        check_rsp("t3.lane1");
        lane1_valid = 1'b1; lane1_addr = 32'h308;
        tick();
        lane1_valid = 1'b0;
        chk("t3.mem_valid_b", 64'(mem_valid), 64'd1);
        chk("t3.mem_addr_b", 64'(mem_addr), 64'h304);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h44440000; push_rsp(1'b0, 32'h44440000, 1'b0);
        tick();
        mem_ready = 1'b0;
        check_rsp("t3.lane0");
        tick();
        chk("t3.mem_addr_c", 64'(mem_addr), 64'h308);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h55550000; mem_error = 1'b1;
        push_rsp(1'b1, 32'h55550000, 1'b1);
        tick();
        mem_ready = 1'b0; mem_error = 1'b0;
        check_rsp("t3.lane1_err");
        chk("t3.overflow", 64'(overflow), 64'd0);
        tick();
        chk("t3.busy", 64'(busy), 64'd0);

        // Timeout with a silent memory, then age order across the abort window.
        lane0_valid = 1'b1; lane0_addr = 32'h400; push_rsp(1'b0, 32'h0, 1'b1);
        tick();
        lane0_valid = 1'b0;
        chk("t4.mem_valid", 64'(mem_valid), 64'd1);
        tick();
        tick();
        lane1_valid = 1'b1; lane1_addr = 32'h404;
        tick();
        lane1_valid = 1'b0;
        tick();
        check_quiet("t4.before_timeout");
        tick();
        check_rsp("t4.timeout");
        tick();
        lane0_valid = 1'b1; lane0_addr = 32'h408;
        tick();
        lane0_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0BAD0BAD;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check_quiet("t4.late_discarded");
        tick();
        chk("t4.mem_addr_old", 64'(mem_addr), 64'h404);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h1234; push_rsp(1'b1, 32'h1234, 1'b0);
        tick();
        mem_ready = 1'b0;
        check_rsp("t4.lane1");
        tick();
        chk("t4.mem_addr_new", 64'(mem_addr), 64'h408);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h5678; push_rsp(1'b0, 32'h5678, 1'b0);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check_rsp("t4.lane0");
        tick();
        chk("t4.busy", 64'(busy), 64'd0);

        // Clear during WAIT with lane 1 queued behind lane 0.
        lane0_valid = 1'b1; lane0_addr = 32'h500;
        tick();
        lane0_valid = 1'b0;
        chk("t5.mem_valid", 64'(mem_valid), 64'd1);
        lane1_valid = 1'b1; lane1_addr = 32'h504;
        tick();
        lane1_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_quiet("t5.after_clear");
        chk("t5.busy_pending", 64'(busy), 64'd1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check_quiet("t5.suppressed");
        chk("t5.busy_done", 64'(busy), 64'd0);
        tick();
        check_quiet("t5.quiet");
        chk("t5.no_issue", 64'(mem_valid), 64'd0);

        // Overflow: second lane 0 pulse while its request is in flight.
        lane0_valid = 1'b1; lane0_addr = 32'h600;
        tick();
        lane0_addr = 32'h6FF;
        tick();
        lane0_valid = 1'b0;
        chk("t6.overflow_set", 64'(overflow), 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'h66; push_rsp(1'b0, 32'h66, 1'b0);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check_rsp("t6.lane0");
        tick();
        chk("t6.dropped", 64'(mem_valid), 64'd0);
        chk("t6.busy", 64'(busy), 64'd0);
        chk("t6.overflow_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset in the middle of WAIT.
        lane1_valid = 1'b1; lane1_addr = 32'h700;
        tick();
        lane1_valid = 1'b0;
        chk("t7.mem_addr", 64'(mem_addr), 64'h700);
        tick();
        #2 reset = 1'b0;
        #1 check_all_zero("t7.async_reset");
        #3 reset = 1'b1;
        tick();
        chk("t7.idle_busy", 64'(busy), 64'd0);
        chk("t7.idle_valid", 64'(mem_valid), 64'd0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
